rom_port_sequencer: RTL and testbench

// Sequences the dual-port instruction ROM (1-cycle synchronous read on both ports).
// - Port A: dedicated to instruction fetch. Holds the fetched word stable across pipeline stalls.
// - Port B: shared by three requesters under arbitration:
//   - load unit (LSU): reads constants from ROM
//   - debug reader (DBG)
//   - background checksum engine (CHK): walks the whole ROM when port B is idle and reports a sum

---
 rtl/rom_port_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_rom_port_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_sequencer.sv
// ---------------------------------------------------------------------------
// rom_port_sequencer
// Sequences a dual-port instruction ROM whose ports each have a 1-cycle
// synchronous read.
//   Port A : instruction fetch. The fetch address is held across stalls so
//            the ROM keeps returning the same word while the pipeline waits.
//   Port B : shared by the load unit (LSU), the debug reader (DBG) and a
//            background checksum engine (CHK). LSU and DBG use round-robin
//            arbitration. CHK only issues when neither of them requests.
// Ports
//   clk, reset                 clock and asynchronous active-high reset
//   if_req/if_addr/if_stall    fetch request, address and pipeline stall
//   if_valid/if_data           fetch result (if_data = rom_douta)
//   lsu_req/lsu_addr           LSU read request
//   lsu_gnt/lsu_rvalid/lsu_rdata  LSU grant, return valid and data
//   dbg_req/dbg_addr           debug read request
//   dbg_gnt/dbg_rvalid/dbg_rdata  debug grant, return valid and data
//   chk_start                  start a checksum scan
//   chk_busy/chk_done/chk_sum  scan status and result
//   rom_addra/rom_douta        ROM port A
//   rom_addrb/rom_doutb        ROM port B
// ---------------------------------------------------------------------------
module rom_port_sequencer #(
   parameter int DEPTH     = 3072,
   parameter int DEPTH_LOG = 12,
   parameter int WIDTH     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_req,
   input  logic [DEPTH_LOG-1:0] if_addr,
   input  logic                 if_stall,
   output logic                 if_valid,
   output logic [WIDTH-1:0]     if_data,
   input  logic                 lsu_req,
   input  logic [DEPTH_LOG-1:0] lsu_addr,
   output logic                 lsu_gnt,
   output logic                 lsu_rvalid,
   output logic [WIDTH-1:0]     lsu_rdata,
   input  logic                 dbg_req,
   input  logic [DEPTH_LOG-1:0] dbg_addr,
   output logic                 dbg_gnt,
   output logic                 dbg_rvalid,
   output logic [WIDTH-1:0]     dbg_rdata,
   input  logic                 chk_start,
   output logic                 chk_busy,
   output logic                 chk_done,
   output logic [WIDTH-1:0]     chk_sum,
   output logic [DEPTH_LOG-1:0] rom_addra,
   input  logic [WIDTH-1:0]     rom_douta,
   output logic [DEPTH_LOG-1:0] rom_addrb,
   input  logic [WIDTH-1:0]     rom_doutb
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic GNT_LSU = 1'b0;
   localparam logic GNT_DBG = 1'b1;

   localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);

   // ---- state ----
   logic [DEPTH_LOG-1:0] held_a_q,     held_a_d;
   logic                 if_valid_q,   if_valid_d;
   logic                 last_gnt_q,   last_gnt_d;
   logic [DEPTH_LOG-1:0] addrb_q;
   logic                 lsu_rvalid_q, dbg_rvalid_q;
   logic                 chk_rvalid_q, chk_last_q;
   logic [1:0]           state_q,      state_d;
   logic [DEPTH_LOG-1:0] scan_addr_q,  scan_addr_d;
   logic                 issued_all_q, issued_all_d;
   logic [WIDTH-1:0]     chk_sum_q,    chk_sum_d;

   logic chk_issue;

   // ---- port A: stall replays the held address so the ROM repeats its word ----
   assign rom_addra = if_stall ? held_a_q : if_addr;
   assign if_valid  = if_valid_q;
   assign if_data   = rom_douta;

   // ---- port B arbitration ----
   // On contention the grant goes to whichever requester was not served last.
   assign lsu_gnt   = lsu_req && (!dbg_req || (last_gnt_q == GNT_DBG));
   assign dbg_gnt   = dbg_req && (!lsu_req || (last_gnt_q == GNT_LSU));
   // The scan only uses port B cycles that LSU and DBG leave completely idle.
   assign chk_issue = (state_q == ST_SCAN) && !issued_all_q && !lsu_req && !dbg_req;

   always_comb begin
      rom_addrb = addrb_q;
      if (lsu_gnt)        rom_addrb = lsu_addr;
      else if (dbg_gnt)   rom_addrb = dbg_addr;
      else if (chk_issue) rom_addrb = scan_addr_q;
   end

   assign lsu_rvalid = lsu_rvalid_q;
   assign dbg_rvalid = dbg_rvalid_q;
   assign lsu_rdata  = rom_doutb;
   assign dbg_rdata  = rom_doutb;

   assign chk_busy = (state_q == ST_SCAN);
   assign chk_done = (state_q == ST_DONE);
   assign chk_sum  = chk_sum_q;

   // ---- next state ----
   always_comb begin
      held_a_d   = held_a_q;
      if_valid_d = if_valid_q;
      if (!if_stall) begin
         held_a_d   = if_addr;
         if_valid_d = if_req;
      end

      last_gnt_d = last_gnt_q;
      if (lsu_gnt)      last_gnt_d = GNT_LSU;
      else if (dbg_gnt) last_gnt_d = GNT_DBG;

      state_d      = state_q;
      scan_addr_d  = scan_addr_q;
      issued_all_d = issued_all_q;
      chk_sum_d    = chk_sum_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (chk_start) begin
               state_d      = ST_SCAN;
               scan_addr_d  = '0;
               issued_all_d = 1'b0;
               chk_sum_d    = '0;
            end
         end
         ST_SCAN: begin
            // chk_start is deliberately ignored while scanning
            if (chk_issue) begin
               scan_addr_d = scan_addr_q + 1'b1;
               if (scan_addr_q == LAST_ADDR) issued_all_d = 1'b1;
            end
            // returns arrive in issue order, so the last-address flag
            // identifies the final word of the scan
            if (chk_rvalid_q) begin
               chk_sum_d = chk_sum_q + rom_doutb;
               if (chk_last_q) state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---- registers; reset also kills any in-flight return ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         held_a_q     <= '0;
         if_valid_q   <= 1'b0;
         last_gnt_q   <= GNT_DBG;
         addrb_q      <= '0;
         lsu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         chk_rvalid_q <= 1'b0;
         chk_last_q   <= 1'b0;
         state_q      <= ST_IDLE;
         scan_addr_q  <= '0;
         issued_all_q <= 1'b0;
         chk_sum_q    <= '0;
      end else begin
         held_a_q     <= held_a_d;
         if_valid_q   <= if_valid_d;
         last_gnt_q   <= last_gnt_d;
         addrb_q      <= rom_addrb;
         lsu_rvalid_q <= lsu_gnt;
         dbg_rvalid_q <= dbg_gnt;
         chk_rvalid_q <= chk_issue;
         chk_last_q   <= chk_issue && (scan_addr_q == LAST_ADDR);
         state_q      <= state_d;
         scan_addr_q  <= scan_addr_d;
         issued_all_q <= issued_all_d;
         chk_sum_q    <= chk_sum_d;
      end
   end

endmodule

// File: tb/tb_rom_port_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rom_port_sequencer
// Self-checking bench for rom_port_sequencer with a small ROM (DEPTH=16).
// A behavioural dual-port ROM sits on both ports. Expected values come from
// the ROM contents and the arbitration/fetch/checksum rules.
// ---------------------------------------------------------------------------
module tb_rom_port_sequencer;

   localparam int DEPTH = 16;
   localparam int DL    = 12;
   localparam int W     = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, if_stall, if_valid;
   logic [DL-1:0] if_addr;
   logic [W-1:0]  if_data;
   logic          lsu_req, lsu_gnt, lsu_rvalid;
   logic [DL-1:0] lsu_addr;
   logic [W-1:0]  lsu_rdata;
   logic          dbg_req, dbg_gnt, dbg_rvalid;
   logic [DL-1:0] dbg_addr;
   logic [W-1:0]  dbg_rdata;
   logic          chk_start, chk_busy, chk_done;
   logic [W-1:0]  chk_sum;
   logic [DL-1:0] rom_addra, rom_addrb;
   logic [W-1:0]  rom_douta, rom_doutb;

   logic [W-1:0]  rom_mem [0:(1<<DL)-1];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   // behavioural ROM, 1-cycle synchronous read on both ports
   always @(posedge clk) begin
      rom_douta <= rom_mem[rom_addra];
      rom_doutb <= rom_mem[rom_addrb];
   end

   rom_port_sequencer #(.DEPTH(DEPTH), .DEPTH_LOG(DL), .WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
      .if_valid(if_valid), .if_data(if_data),
      .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_gnt(lsu_gnt),
      .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
      .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .chk_start(chk_start), .chk_busy(chk_busy), .chk_done(chk_done),
      .chk_sum(chk_sum),
      .rom_addra(rom_addra), .rom_douta(rom_douta),
      .rom_addrb(rom_addrb), .rom_doutb(rom_doutb)
   );

   // ---- stimulus helpers (no checking inside) ----
   task automatic idle_inputs();
      if_req = 0; if_addr = '0; if_stall = 0;
      lsu_req = 0; lsu_addr = '0; dbg_req = 0; dbg_addr = '0;
      chk_start = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < (1 << DL); i++) rom_mem[i] = (i < DEPTH) ? W'(i + 1) : 32'hDEAD_0000;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      chk_start = 1;
      @(negedge clk);
      chk_start = 0;
   endtask

   // waits for chk_done; n = cycles after the start edge, -1 on timeout
   task automatic wait_done(output int n, output bit busy_drop);
      n = 0; busy_drop = 0;
      while (!chk_done) begin
         if (!chk_busy) busy_drop = 1;
         @(negedge clk);
         n++;
         if (n > 400) begin n = -1; return; end
      end
   endtask

   // ---- tests ----
   task automatic test_reset();
      idle_inputs();
      reset = 1;
      repeat (2) @(negedge clk);
      vectors++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %0h exp 0", if_valid); end
      vectors++; if (lsu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_lsu_rvalid got %0h exp 0", lsu_rvalid); end
      vectors++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dbg_rvalid got %0h exp 0", dbg_rvalid); end
      vectors++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL reset_chk_busy got %0h exp 0", chk_busy); end
      vectors++; if (chk_done !== 1'b0) begin errors++; $display("FAIL reset_chk_done got %0h exp 0", chk_done); end
      vectors++; if (chk_sum !== '0) begin errors++; $display("FAIL reset_chk_sum got %0h exp 0", chk_sum); end
      vectors++; if (rom_addrb !== '0) begin errors++; $display("FAIL reset_rom_addrb got %0h exp 0", rom_addrb); end
      reset = 0;
   endtask

   task automatic test_fetch();
      logic [DL-1:0] m_held, prev_held;
      logic          m_vld;
      for (int i = 0; i < (1 << DL); i++) rom_mem[i] = $urandom;
      rom_mem[5] = 32'hA5A5_0005;
      rom_mem[9] = 32'h9999_0009;
      @(negedge clk);
      if_req = 1; if_addr = 5; if_stall = 0;
      @(negedge clk);
      if_stall = 1; if_addr = 9;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vectors++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_stall_valid cyc %0d got %0h exp 1", k, if_valid); end
         vectors++; if (if_data !== 32'hA5A5_0005) begin errors++; $display("FAIL fetch_stall_data cyc %0d got %0h exp a5a50005", k, if_data); end
      end
      if_stall = 0;
      @(negedge clk);
      vectors++; if (if_data !== 32'h9999_0009) begin errors++; $display("FAIL fetch_release_data got %0h exp 99990009", if_data); end
      // random fetch/stall traffic: the result is always the word at the
      // last unstalled address, valid = the request seen with it
      m_held = 9; m_vld = 1;
      for (int k = 0; k < 150; k++) begin
         if_req   = 1'($urandom_range(0, 1));
         if_addr  = DL'($urandom_range(0, DEPTH - 1));
         if_stall = ($urandom_range(0, 9) < 4);
         prev_held = m_held;
         #1;
         vectors++; if (rom_addra !== (if_stall ? prev_held : if_addr)) begin errors++; $display("FAIL fetch_rand_addra cyc %0d got %0h exp %0h", k, rom_addra, if_stall ? prev_held : if_addr); end
         if (!if_stall) begin m_held = if_addr; m_vld = if_req; end
         @(negedge clk);
         vectors++; if (if_valid !== m_vld) begin errors++; $display("FAIL fetch_rand_valid cyc %0d got %0h exp %0h", k, if_valid, m_vld); end
         vectors++; if (if_data !== rom_mem[m_held]) begin errors++; $display("FAIL fetch_rand_data cyc %0d got %0h exp %0h", k, if_data, rom_mem[m_held]); end
      end
      idle_inputs();
   endtask

   task automatic test_arbitration();
      bit            m_last;     // 0: LSU served last, 1: DBG served last
      bit            g_l, g_d, e_lrv, e_drv;
      logic [DL-1:0] m_addrb, e_laddr, e_daddr;
      for (int i = 0; i < (1 << DL); i++) rom_mem[i] = $urandom;
      do_reset();
      lsu_req = 1; lsu_addr = 3; dbg_req = 1; dbg_addr = 7;
      for (int k = 0; k < 4; k++) begin
         #1;
         vectors++; if ({lsu_gnt, dbg_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL arb_dir_gnt cyc %0d got %b%b exp %s", k, lsu_gnt, dbg_gnt, (k % 2 == 0) ? "LSU" : "DBG"); end
         vectors++; if (rom_addrb !== ((k % 2 == 0) ? DL'(3) : DL'(7))) begin errors++; $display("FAIL arb_dir_addrb cyc %0d got %0h", k, rom_addrb); end
         @(negedge clk);
         vectors++; if ({lsu_rvalid, dbg_rvalid} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL arb_dir_rvalid cyc %0d got %b%b", k, lsu_rvalid, dbg_rvalid); end
         vectors++; if (lsu_rdata !== rom_mem[(k % 2 == 0) ? 3 : 7]) begin errors++; $display("FAIL arb_dir_rdata cyc %0d got %0h exp %0h", k, lsu_rdata, rom_mem[(k % 2 == 0) ? 3 : 7]); end
      end
      lsu_req = 0; dbg_req = 0;
      @(negedge clk);
      vectors++; if ({lsu_rvalid, dbg_rvalid} !== 2'b00) begin errors++; $display("FAIL arb_rvalid_one_cycle got %b%b exp 00", lsu_rvalid, dbg_rvalid); end
      // random traffic; each requester holds until granted
      m_last = 1; m_addrb = 7; e_lrv = 0; e_drv = 0; e_laddr = '0; e_daddr = '0;
      for (int k = 0; k < 300; k++) begin
         if (!lsu_req) begin lsu_req = 1'($urandom_range(0, 1)); lsu_addr = DL'($urandom_range(0, DEPTH - 1)); end
         if (!dbg_req) begin dbg_req = 1'($urandom_range(0, 1)); dbg_addr = DL'($urandom_range(0, DEPTH - 1)); end
         #1;
         g_l = lsu_req && (!dbg_req || m_last);
         g_d = dbg_req && (!lsu_req || !m_last);
         if (g_l) m_addrb = lsu_addr; else if (g_d) m_addrb = dbg_addr;
         vectors++; if ({lsu_gnt, dbg_gnt} !== {g_l, g_d}) begin errors++; $display("FAIL arb_rand_gnt cyc %0d got %b%b exp %b%b", k, lsu_gnt, dbg_gnt, g_l, g_d); end
         vectors++; if (rom_addrb !== m_addrb) begin errors++; $display("FAIL arb_rand_addrb cyc %0d got %0h exp %0h", k, rom_addrb, m_addrb); end
         if (g_l) m_last = 0; else if (g_d) m_last = 1;
         e_lrv = g_l; e_drv = g_d; e_laddr = lsu_addr; e_daddr = dbg_addr;
         @(negedge clk);
         vectors++; if ({lsu_rvalid, dbg_rvalid} !== {e_lrv, e_drv}) begin errors++; $display("FAIL arb_rand_rvalid cyc %0d got %b%b exp %b%b", k, lsu_rvalid, dbg_rvalid, e_lrv, e_drv); end
         if (e_lrv) begin vectors++; if (lsu_rdata !== rom_mem[e_laddr]) begin errors++; $display("FAIL arb_rand_lsu_data cyc %0d got %0h exp %0h", k, lsu_rdata, rom_mem[e_laddr]); end end
         if (e_drv) begin vectors++; if (dbg_rdata !== rom_mem[e_daddr]) begin errors++; $display("FAIL arb_rand_dbg_data cyc %0d got %0h exp %0h", k, dbg_rdata, rom_mem[e_daddr]); end end
         if (g_l) lsu_req = 0;
         if (g_d) dbg_req = 0;
      end
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_checksum();
      int n; bit drop;
      fill_ramp();
      do_reset();
      pulse_start();
      wait_done(n, drop);
      vectors++; if (n < DEPTH + 1) begin errors++; $display("FAIL chk_cycles got %0d exp >= %0d", n, DEPTH + 1); end
      vectors++; if (drop !== 1'b0) begin errors++; $display("FAIL chk_busy_during_scan got drop=%0d exp 0", drop); end
      vectors++; if (chk_sum !== 32'd136) begin errors++; $display("FAIL chk_sum got %0d exp 136", chk_sum); end
      vectors++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL chk_busy_after_done got %0h exp 0", chk_busy); end
   endtask

   task automatic test_wrap_contention();
      int n;
      for (int i = 0; i < (1 << DL); i++) rom_mem[i] = (i < DEPTH) ? 32'hFFFF_FFFF : 32'h0;
      lsu_addr = 100;       // outside the scan range, ROM holds 0 there
      pulse_start();        // restart from DONE
      n = 0;
      while (!chk_done && n < 400) begin
         lsu_req = (n % 2 == 0);
         #1;
         if (lsu_req) begin
            vectors++; if (lsu_gnt !== 1'b1 || rom_addrb !== DL'(100)) begin errors++; $display("FAIL wrap_lsu_priority cyc %0d got gnt=%0h addrb=%0h exp 1/64", n, lsu_gnt, rom_addrb); end
         end else if (chk_busy) begin
            vectors++; if (rom_addrb >= DL'(DEPTH)) begin errors++; $display("FAIL wrap_chk_addr_range cyc %0d got %0h exp < %0d", n, rom_addrb, DEPTH); end
         end
         @(negedge clk);
         n++;
      end
      lsu_req = 0;
      vectors++; if (chk_done !== 1'b1) begin errors++; $display("FAIL wrap_done got %0h exp 1", chk_done); end
      vectors++; if (chk_sum !== 32'hFFFF_FFF0) begin errors++; $display("FAIL wrap_sum got %0h exp fffffff0", chk_sum); end
   endtask

   task automatic test_reset_mid_scan();
      int n; bit drop, found;
      fill_ramp();
      pulse_start();
      found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         #1;
         if (chk_busy && rom_addrb == DL'(8)) found = 1;
         else @(negedge clk);
      end
      vectors++; if (!found) begin errors++; $display("FAIL rst_reach_addr8 got none exp addr 8 issued"); end
      // put an LSU read in flight, then reset while its rvalid is up
      lsu_req = 1; lsu_addr = 2;
      @(posedge clk); #1;
      lsu_req = 0;
      vectors++; if (lsu_rvalid !== 1'b1) begin errors++; $display("FAIL rst_pre_rvalid got %0h exp 1", lsu_rvalid); end
      reset = 1;
      #1;
      vectors++; if (lsu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid_drop got %0h exp 0", lsu_rvalid); end
      vectors++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", chk_busy); end
      vectors++; if (chk_sum !== '0) begin errors++; $display("FAIL rst_sum got %0h exp 0", chk_sum); end
      repeat (2) @(negedge clk);
      reset = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         vectors++; if ({lsu_rvalid, dbg_rvalid, chk_busy, chk_done} !== 4'b0) begin errors++; $display("FAIL rst_post_quiet cyc %0d got %b%b%b%b exp 0000", k, lsu_rvalid, dbg_rvalid, chk_busy, chk_done); end
      end
      pulse_start();
      wait_done(n, drop);
      vectors++; if (n < 0 || chk_sum !== 32'd136) begin errors++; $display("FAIL rst_rescan_sum got %0d (n=%0d) exp 136", chk_sum, n); end
   endtask

   task automatic test_ignored_restart();
      int n;
      bit drop;
      fill_ramp();
      pulse_start();
      n = 0; drop = 0;
      while (!chk_done && n < 400) begin
         if (!chk_busy) drop = 1;
         chk_start = (n == 5);
         @(negedge clk);
         n++;
      end
      chk_start = 0;
      vectors++; if (drop !== 1'b0) begin errors++; $display("FAIL restart_busy got drop=%0d exp 0", drop); end
      vectors++; if (n > DEPTH + 1) begin errors++; $display("FAIL restart_cycles got %0d exp <= %0d", n, DEPTH + 1); end
      vectors++; if (chk_sum !== 32'd136) begin errors++; $display("FAIL restart_sum got %0d exp 136", chk_sum); end
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      fill_ramp();
      test_reset();
      test_fetch();
      test_arbitration();
      test_checksum();
      test_wrap_contention();
      test_reset_mid_scan();
      test_ignored_restart();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
